game_scheduler: RTL
===================

Name: game_scheduler

Overview:
- Frame-synchronous game controller that sequences the VGA renderer.
- Owns all object positions (raccoon, 3 cars), the lives count, the level and the game state.
- Advances them exactly once per video frame, detected from the renderer's vertical sync.
- Feeds the renderer's raccoonX/Y and carX/Y_1..3 inputs directly.

Parameters:
- GRID, 32, raccoon step size in pixels.
- SCREEN_W, 640, active width in pixels.
- SCREEN_H, 480, active height in pixels.
- PLAYER_W / PLAYER_H, 32 / 32, raccoon size.
- CAR_W / CAR_H, 64 / 32, car size.
- START_X / START_Y, 320 / 448, raccoon spawn point.
- LANE_Y_1 / LANE_Y_2 / LANE_Y_3, 128 / 224 / 320, fixed car Y positions.
- CAR_X0_1 / CAR_X0_2 / CAR_X0_3, 0 / 320 / 160, car X positions after reset.
- MAX_LEVEL, 7, level saturation value.
- HIT_FRAMES, 60, number of frozen frames after a collision.
- START_LIVES, 3, lives at game start.

Ports:
- clk  in  1  system clock (same clock as the VGA renderer).
- rst_n  in  1  synchronous reset, active-low.
- vga_vs  in  1  renderer vertical sync, active-low pulse.
- btn_up / btn_down / btn_left / btn_right  in  1 each  debounced, synchronised level inputs.
- btn_start  in  1  debounced, synchronised level input.
- raccoon_x / raccoon_y  out  10 each  raccoon top-left position.
- car_x_1 / car_x_2 / car_x_3  out  10 each  car X positions.
- car_y_1 / car_y_2 / car_y_3  out  10 each  car Y positions; constant LANE_Y_n.
- lives  out  2  remaining lives.
- level  out  3  current level, range 1..MAX_LEVEL.
- game_state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - raccoon = (START_X, START_Y); car_x_n = CAR_X0_n.
  - lives = START_LIVES; level = 1; game_state = IDLE.
  - All pending moves and hit_cnt cleared.
  - Asserting reset mid-game aborts immediately; no partial update survives.
- frame_tick:
  - vs_q <= vga_vs; frame_tick = vga_vs & ~vs_q (rising edge, end of sync).
  - It is high for exactly one cycle per frame.
- Button edges:
  - press_x = btn_x & ~btn_x_q.
  - A direction press sets its pending flag.
  - All four pending flags clear on every frame_tick, whether or not a move was consumed.
  - A press arriving in the same cycle as frame_tick is taken into that tick's decision.
  - Pending flags are only collected in PLAY; outside PLAY they are held clear.
- IDLE: press of btn_start -> PLAY. Nothing moves.
- PLAY, on frame_tick (all updates registered, visible one cycle after the tick):
  - Raccoon makes at most one move per frame. Priority: up > down > left > right.
  - up: y >= GRID ? y-GRID : y.
  - down: y+GRID <= SCREEN_H-PLAYER_H ? y+GRID : y.
  - left: x >= GRID ? x-GRID : x.
  - right: x+GRID <= SCREEN_W-PLAYER_W ? x+GRID : x.
  - Car 1 and car 3 move right by `level` px; car 2 moves left by `level`+1 px.
  - Right wrap: x+s >= SCREEN_W -> x+s-SCREEN_W.
  - Left wrap: x < s -> x+SCREEN_W-s.
  - All sums are computed in 11 bits; the result is always 0..SCREEN_W-1.
- PLAY, every cycle:
  - Collision is AABB overlap against each car: rx < cx+CAR_W && cx < rx+PLAYER_W && ry < cy+CAR_H && cy < ry+PLAYER_H.
  - All comparisons are 11-bit.
  - On collision: lives <= lives-1; hit_cnt <= 0; -> HIT.
  - Win is raccoon_y == 0 with no collision: level <= min(level+1, MAX_LEVEL); raccoon <= START; stay in PLAY.
  - If collision and win occur in the same cycle, collision wins.
  - btn_start is ignored in PLAY.
- HIT:
  - All positions are frozen; hit_cnt increments on each frame_tick.
  - When hit_cnt reaches HIT_FRAMES-1 and frame_tick is high:
    - lives == 0 -> OVER; positions stay frozen.
    - lives != 0 -> raccoon <= START; -> PLAY.
- OVER:
  - Frozen.
  - btn_start press -> lives = START_LIVES, level = 1, raccoon = START, car_x_n = CAR_X0_n, -> PLAY.
- lives never underflows; a collision is only possible while lives >= 1.

Decomposition:
- Shared constants include file holds GRID, SCREEN_W/H, PLAYER_W/H, CAR_W/H and the game_state encodings.
- These are shared with the VGA renderer.
- Sub-module car_lane holds one car's X register with direction, speed input, tick enable, and wrap logic.
- game_scheduler instantiates car_lane 3 times.
- Button edge logic, collision logic and the FSM stay inline.

Test Plan:
- Reset, then btn_start pulse -> game_state=1 on the next cycle; raccoon=(320,448), car_x=(0,320,160), lives=3, level=1.
- PLAY, one up press then 1 tick -> raccoon_y=416; car_x_1=1, car_x_2=318, car_x_3=161.
- Up and right pressed before the same tick -> only up applied; right flag discarded; raccoon_x stays 320.
- Car wrap: car_x_1=639 at level 1 plus tick -> 0. car_x_2=1 with speed 2 plus tick -> 639.
- Collision: raccoon moved into lane 1 overlapping car 1 -> HIT, lives=2; positions frozen 60 ticks; then raccoon=(320,448), PLAY.
- Three collisions -> OVER after 60 frames with lives=0. Win at y=0 with level=7 -> level stays 7, raccoon respawns. rst_n=0 during HIT -> IDLE, lives=3.

Source files
------------

// File: rtl/game_scheduler_pkg.sv
// Shared game constants, state encoding and the AABB overlap helper.
// Geometry constants are common with the VGA renderer.
package game_scheduler_pkg;

    localparam logic [10:0] GRID     = 11'd32;
    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [10:0] SCREEN_H = 11'd480;
    localparam logic [10:0] PLAYER_W = 11'd32;
    localparam logic [10:0] PLAYER_H = 11'd32;
    localparam logic [10:0] CAR_W    = 11'd64;
    localparam logic [10:0] CAR_H    = 11'd32;

    localparam logic [9:0] START_X  = 10'd320;
    localparam logic [9:0] START_Y  = 10'd448;
    localparam logic [9:0] LANE_Y_1 = 10'd128;
    localparam logic [9:0] LANE_Y_2 = 10'd224;
    localparam logic [9:0] LANE_Y_3 = 10'd320;
    localparam logic [9:0] CAR_X0_1 = 10'd0;
    localparam logic [9:0] CAR_X0_2 = 10'd320;
    localparam logic [9:0] CAR_X0_3 = 10'd160;

    localparam logic [2:0] MAX_LEVEL   = 3'd7;
    localparam int         HIT_FRAMES  = 60;
    localparam logic [5:0] HIT_LAST    = 6'(HIT_FRAMES - 1);
    localparam logic [1:0] START_LIVES = 2'd3;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_START = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    function automatic logic aabb_hit(input logic [10:0] rx, input logic [10:0] ry,
                                      input logic [10:0] cx, input logic [10:0] cy);
        return (rx < cx + CAR_W) && (cx < rx + PLAYER_W) &&
               (ry < cy + CAR_H) && (cy < ry + PLAYER_H);
    endfunction

endpackage

// File: rtl/game_scheduler_car_lane.sv
// One car's X position: moves by speed_i on each tick, wrapping within the screen width.
// Latency: new position one cycle after tick_i. Backpressure: none.
// load_i restores the spawn position and takes priority over tick_i.
module game_scheduler_car_lane
    import game_scheduler_pkg::*;
#(
    parameter logic [9:0] X0        = 10'd0,
    parameter bit         MOVE_LEFT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       tick_i,
    input  logic [3:0] speed_i,
    output logic [9:0] x_o
);

    logic [9:0]  x_q, x_d;
    logic [10:0] x_w, s_w;

    always_comb begin
        x_w = {1'b0, x_q};
        s_w = {7'd0, speed_i};
        x_d = x_q;
        if (load_i) begin
            x_d = X0;
        end else if (tick_i) begin
            if (MOVE_LEFT) begin
                x_d = (x_w < s_w) ? 10'(x_w + SCREEN_W - s_w) : 10'(x_w - s_w);
            end else begin
                x_d = (x_w + s_w >= SCREEN_W) ? 10'(x_w + s_w - SCREEN_W) : 10'(x_w + s_w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= X0;
        end else begin
            x_q <= x_d;
        end
    end

    assign x_o = x_q;

endmodule

// File: rtl/game_scheduler.sv
// Frame-synchronous game controller: raccoon, cars, lives, level and game state.
// Latency: frame updates visible one cycle after the vsync rising edge. Backpressure: none.
// Buttons are sampled as levels every cycle; presses are latched until the next frame.
module game_scheduler
    import game_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vga_vs,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [9:0] raccoon_x,
    output logic [9:0] raccoon_y,
    output logic [9:0] car_x_1,
    output logic [9:0] car_x_2,
    output logic [9:0] car_x_3,
    output logic [9:0] car_y_1,
    output logic [9:0] car_y_2,
    output logic [9:0] car_y_3,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [1:0] game_state
);

    game_state_e state_q;
    logic        vs_q;
    logic [4:0]  btn_q;
    logic [3:0]  pend_q;
    logic [9:0]  rx_q, ry_q;
    logic [1:0]  lives_q;
    logic [2:0]  level_q;
    logic [5:0]  hit_q;

    logic        frame_tick;
    logic [4:0]  btn_w, press_w;
    logic [3:0]  pend_w;
    logic [9:0]  cx1_w, cx2_w, cx3_w;
    logic        collide_w, car_tick_w, car_load_w;
    logic [3:0]  spd_r_w, spd_l_w;
    logic [10:0] rx_w, ry_w;
    logic [9:0]  mv_x, mv_y;

    assign frame_tick = vga_vs & ~vs_q;
    assign btn_w      = {btn_start, btn_right, btn_left, btn_down, btn_up};
    assign press_w    = btn_w & ~btn_q;
    // A press landing on the tick cycle still counts for that tick.
    assign pend_w     = pend_q | press_w[3:0];

    assign rx_w = {1'b0, rx_q};
    assign ry_w = {1'b0, ry_q};

    assign collide_w = aabb_hit(rx_w, ry_w, {1'b0, cx1_w}, {1'b0, LANE_Y_1}) |
                       aabb_hit(rx_w, ry_w, {1'b0, cx2_w}, {1'b0, LANE_Y_2}) |
                       aabb_hit(rx_w, ry_w, {1'b0, cx3_w}, {1'b0, LANE_Y_3});

    always_comb begin
        mv_x = rx_q;
        mv_y = ry_q;
        if (pend_w[BTN_UP]) begin
            if (ry_w >= GRID) mv_y = 10'(ry_w - GRID);
        end else if (pend_w[BTN_DOWN]) begin
            if (ry_w + GRID <= SCREEN_H - PLAYER_H) mv_y = 10'(ry_w + GRID);
        end else if (pend_w[BTN_LEFT]) begin
            if (rx_w >= GRID) mv_x = 10'(rx_w - GRID);
        end else if (pend_w[BTN_RIGHT]) begin
            if (rx_w + GRID <= SCREEN_W - PLAYER_W) mv_x = 10'(rx_w + GRID);
        end
    end

    assign car_tick_w = frame_tick && (state_q == ST_PLAY) && !collide_w;
    assign car_load_w = (state_q == ST_OVER) && press_w[BTN_START];
    assign spd_r_w    = {1'b0, level_q};
    assign spd_l_w    = {1'b0, level_q} + 4'd1;

    game_scheduler_car_lane #(.X0(CAR_X0_1), .MOVE_LEFT(1'b0)) u_car_1 (
        .clk(clk), .rst_n(rst_n), .load_i(car_load_w), .tick_i(car_tick_w),
        .speed_i(spd_r_w), .x_o(cx1_w)
    );
    game_scheduler_car_lane #(.X0(CAR_X0_2), .MOVE_LEFT(1'b1)) u_car_2 (
        .clk(clk), .rst_n(rst_n), .load_i(car_load_w), .tick_i(car_tick_w),
        .speed_i(spd_l_w), .x_o(cx2_w)
    );
    game_scheduler_car_lane #(.X0(CAR_X0_3), .MOVE_LEFT(1'b0)) u_car_3 (
        .clk(clk), .rst_n(rst_n), .load_i(car_load_w), .tick_i(car_tick_w),
        .speed_i(spd_r_w), .x_o(cx3_w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vs_q    <= 1'b1;
            btn_q   <= '0;
            pend_q  <= '0;
            rx_q    <= START_X;
            ry_q    <= START_Y;
            lives_q <= START_LIVES;
            level_q <= 3'd1;
            hit_q   <= '0;
        end else begin
            vs_q   <= vga_vs;
            btn_q  <= btn_w;
            pend_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (press_w[BTN_START]) state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (collide_w) begin
                        lives_q <= lives_q - 2'd1;
                        hit_q   <= '0;
                        state_q <= ST_HIT;
                    end else begin
                        if (!frame_tick) pend_q <= pend_w;
                        if (ry_q == 10'd0) begin
                            level_q <= (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 3'd1;
                            rx_q    <= START_X;
                            ry_q    <= START_Y;
                        end else if (frame_tick) begin
                            rx_q <= mv_x;
                            ry_q <= mv_y;
                        end
                    end
                end
                ST_HIT: begin
                    if (frame_tick) begin
                        hit_q <= hit_q + 6'd1;
                        if (hit_q == HIT_LAST) begin
                            if (lives_q == 2'd0) begin
                                state_q <= ST_OVER;
                            end else begin
                                rx_q    <= START_X;
                                ry_q    <= START_Y;
                                state_q <= ST_PLAY;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (press_w[BTN_START]) begin
                        lives_q <= START_LIVES;
                        level_q <= 3'd1;
                        rx_q    <= START_X;
                        ry_q    <= START_Y;
                        state_q <= ST_PLAY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign raccoon_x  = rx_q;
    assign raccoon_y  = ry_q;
    assign car_x_1    = cx1_w;
    assign car_x_2    = cx2_w;
    assign car_x_3    = cx3_w;
    assign car_y_1    = LANE_Y_1;
    assign car_y_2    = LANE_Y_2;
    assign car_y_3    = LANE_Y_3;
    assign lives      = lives_q;
    assign level      = level_q;
    assign game_state = state_q;

endmodule
